// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver (and the
// transmitter that will later reuse the baud tick generator).
package uart_pkg;

    // Receiver frame state machine encoding
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DELIVER,
        WAIT_HIGH
    } uart_state_e;

    // parity_mode encodings; 2'b11 also means "no parity"
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Expected parity bit for a word. Narrower words are zero-extended
    // by the caller, which leaves the XOR reduction unchanged.
    function automatic logic parity_calc(input logic [31:0] data,
                                         input logic [1:0]  mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

    // Only the two explicit modes carry a parity bit on the line
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..baud_div_i and pulses tick_o on the
// terminal count, then wraps. baud_div_i = 0 gives a tick every cycle.
// clr_i holds the counter at zero so a frame starts on a fresh tick phase.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= keeps the counter bounded if baud_div shrinks while running
    assign tick_o = !clr_i && (cnt_q >= baud_div_i);

    // Next count: wrap on tick, otherwise advance
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Divider counter register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, runtime baud
// divider, parity mode and stop-bit count, valid/ready output handshake
// and overrun detection.
// Optional build macro: UART_RX_BREAK_DETECT_EN adds the brk output; an
// all-zero frame then pulses brk instead of delivering a word.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic              brk,
`endif
    output logic              busy
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SAMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SAMP_B   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SAMP_C   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    // Synchroniser and edge detect
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rx_s;
    logic fall;

    // Frame timing
    logic            tick;
    logic [OS_W-1:0] os_cnt_q;
    logic [1:0]      samp_q;
    logic            decide;
    logic            bit_d;

    // Frame state
    uart_state_e       state_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [1:0]        par_mode_q;
    logic              two_stop_q;
    logic              perr_q;
    logic              ferr_q;
    logic              zero_q;

    // Output registers
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              perr_out_q;
    logic              ferr_out_q;
    logic              overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
    logic              brk_q;
`endif

    assign rx_s = sync2_q;
    assign fall = prev_q && !rx_s;

    // The third vote is the live synchronised sample at the decision tick
    assign decide = tick && (os_cnt_q == SAMP_C);
    assign bit_d  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // Tick phase is held at zero in IDLE so START begins a fresh bit period
    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (state_q == IDLE),
        .baud_div_i (baud_div),
        .tick_o     (tick)
    );

    // Two-flop synchroniser plus previous-value flop for falling-edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame FSM with oversample counter, bit assembly and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            os_cnt_q   <= '0;
            samp_q     <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q     <= 1'b0;
`endif
            // Accept clears valid; a DELIVER load below overrides this
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (tick) begin
                os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
                if (os_cnt_q == SAMP_A) samp_q[0] <= rx_s;
                if (os_cnt_q == SAMP_B) samp_q[1] <= rx_s;
            end

            case (state_q)
                IDLE: begin
                    os_cnt_q <= '0;
                    if (fall) begin
                        state_q    <= START;
                        par_mode_q <= parity_mode;
                        two_stop_q <= two_stop;
                        bit_idx_q  <= '0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        zero_q     <= 1'b1;
                    end
                end

                START: begin
                    if (decide) begin
                        bit_idx_q <= '0;
                        state_q   <= bit_d ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (decide) begin
                        shreg_q[bit_idx_q] <= bit_d;
                        zero_q             <= zero_q & ~bit_d;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= parity_enabled(par_mode_q) ? PARITY : STOP1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (decide) begin
                        perr_q  <= (bit_d != parity_calc(32'(shreg_q), par_mode_q));
                        zero_q  <= zero_q & ~bit_d;
                        state_q <= STOP1;
                    end
                end

                STOP1: begin
                    if (decide) begin
                        ferr_q  <= ferr_q | ~bit_d;
                        zero_q  <= zero_q & ~bit_d;
                        state_q <= two_stop_q ? STOP2 : DELIVER;
                    end
                end

                STOP2: begin
                    if (decide) begin
                        ferr_q  <= ferr_q | ~bit_d;
                        zero_q  <= zero_q & ~bit_d;
                        state_q <= DELIVER;
                    end
                end

                DELIVER: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (zero_q) begin
                        brk_q   <= 1'b1;
                        state_q <= WAIT_HIGH;
                    end else
`endif
                    begin
                        if (!m_valid_q || m_ready) begin
                            m_data_q   <= shreg_q;
                            perr_out_q <= perr_q;
                            ferr_out_q <= ferr_q;
                            m_valid_q  <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        state_q <= rx_s ? IDLE : WAIT_HIGH;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign brk        = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param (DATA_W=8, OVERSAMPLE=16, baud_div=3,
// so one bit time is 64 clocks).
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT_CYC = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        brk;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Event counters maintained by the monitor
    int         valid_cyc = 0;
    int         acc_cnt   = 0;
    int         ovr_cnt   = 0;
    int         brk_cnt   = 0;
    logic [7:0] acc_data  = '0;
    logic       acc_perr  = 1'b0;
    logic       acc_ferr  = 1'b0;

    // Baselines taken before each step
    int a0, v0, o0, b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_W     (8),
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
`ifdef UART_RX_BREAK_DETECT_EN
        .brk         (brk),
`endif
        .busy        (busy)
    );

    // Monitor on the inactive edge: record handshakes and pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) valid_cyc++;
            if (m_valid && m_ready) begin
                acc_cnt++;
                acc_data = m_data;
                acc_perr = parity_err;
                acc_ferr = frame_err;
            end
            if (overrun) ovr_cnt++;
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk) brk_cnt++;
`endif
        end
    end

    // Watchdog: every step is a fixed-length sequence, this only guards the run
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        idle(n);
    endtask

    // Frame: start, 8 data LSB first, optional parity, stop1, optional stop2.
    // gbit >= 0 inverts that data bit for 4 clocks (one oversample tick)
    // around the middle of the bit.
    task automatic send_frame(input logic [7:0] d, input int pbit, input logic st1,
                              input int nstop, input logic st2, input int gbit);
        logic b[12];
        int   n;
        n = 0;
        b[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i]; n++;
        end
        if (pbit >= 0) begin
            b[n] = (pbit != 0); n++;
        end
        b[n] = st1; n++;
        if (nstop == 2) begin
            b[n] = st2; n++;
        end
        for (int k = 0; k < n; k++) begin
            if (gbit >= 0 && k == gbit + 1) begin
                drive_bit(b[k], 35);
                drive_bit(~b[k], 4);
                drive_bit(b[k], BIT_CYC - 39);
            end else begin
                drive_bit(b[k], BIT_CYC);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rx          = 1'b1;
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        m_ready     = 1'b1;
        idle(4);

        // Reset state
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(10);

        // Basic frame 0xA5
        a0 = acc_cnt; v0 = valid_cyc;
        send_frame(8'hA5, -1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("basic_accepts", acc_cnt - a0, 1);
        check("basic_data", acc_data, 8'hA5);
        check("basic_perr", acc_perr, 0);
        check("basic_ferr", acc_ferr, 0);
        check("basic_valid_cycles", valid_cyc - v0, 1);
        check("basic_valid_low", m_valid, 0);
        check("basic_busy_low", busy, 0);

        // Even parity, 0x07 with parity bit 1: correct
        parity_mode = 2'b01;
        send_frame(8'h07, 1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("even_data", acc_data, 8'h07);
        check("even_perr", acc_perr, 0);

        // Odd parity, same bits: parity error
        parity_mode = 2'b10;
        a0 = acc_cnt;
        send_frame(8'h07, 1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("odd_accepts", acc_cnt - a0, 1);
        check("odd_data", acc_data, 8'h07);
        check("odd_perr", acc_perr, 1);
        check("odd_ferr", acc_ferr, 0);
        parity_mode = 2'b00;

        // Handshake and overrun
        m_ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(8'h11, -1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("hold_valid_1", m_valid, 1);
        check("hold_data_1", m_data, 8'h11);
        send_frame(8'h22, -1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("hold_valid_2", m_valid, 1);
        check("hold_data_2", m_data, 8'h11);
        check("overrun_pulses", ovr_cnt - o0, 1);
        check("hold_no_accept", acc_cnt - a0, 0);
        m_ready = 1'b1;
        idle(3);
        check("release_accepts", acc_cnt - a0, 1);
        check("release_data", acc_data, 8'h11);
        check("release_valid_low", m_valid, 0);
        check("release_overrun_total", ovr_cnt - o0, 1);

        // Two stop bits, second one bad, line then held low
        two_stop = 1'b1;
        a0 = acc_cnt;
        send_frame(8'h3C, -1, 1'b1, 2, 1'b0, -1);
        idle(3 * BIT_CYC);
        check("stop2_accepts", acc_cnt - a0, 1);
        check("stop2_data", acc_data, 8'h3C);
        check("stop2_ferr", acc_ferr, 1);
        check("stop2_perr", acc_perr, 0);
        check("held_low_busy", busy, 1);
        drive_bit(1'b1, 10);
        check("released_busy", busy, 0);
        idle(2 * BIT_CYC);
        check("held_low_no_frame", acc_cnt - a0, 1);
        two_stop = 1'b0;

        // Short low pulse in IDLE: rejected as a glitch
        a0 = acc_cnt; v0 = valid_cyc;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 2 * BIT_CYC);
        check("glitch_no_valid", valid_cyc - v0, 0);
        check("glitch_busy", busy, 0);

        // One-tick inverted glitches at data sample points
        send_frame(8'hC3, -1, 1'b1, 1, 1'b1, 0);
        idle(20);
        send_frame(8'hC3, -1, 1'b1, 1, 1'b1, 2);
        idle(20);
        check("noise_accepts", acc_cnt - a0, 2);
        check("noise_data", acc_data, 8'hC3);
        check("noise_ferr", acc_ferr, 0);

        // Reset mid-DATA with a word pending
        m_ready = 1'b0;
        send_frame(8'h99, -1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("pre_reset_valid", m_valid, 1);
        drive_bit(1'b0, BIT_CYC);
        drive_bit(1'b1, BIT_CYC);
        drive_bit(1'b0, BIT_CYC);
        drive_bit(1'b1, 20);
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_busy", busy, 0);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        idle(10);
        a0 = acc_cnt;
        send_frame(8'h5A, -1, 1'b1, 1, 1'b1, -1);
        idle(20);
        check("post_rst_accepts", acc_cnt - a0, 1);
        check("post_rst_data", acc_data, 8'h5A);
        check("post_rst_ferr", acc_ferr, 0);

        // Break: 12 bit times low
        a0 = acc_cnt; v0 = valid_cyc; b0 = brk_cnt; o0 = ovr_cnt;
        drive_bit(1'b0, 12 * BIT_CYC);
        drive_bit(1'b1, 2 * BIT_CYC);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_pulse", brk_cnt - b0, 1);
        check("break_no_valid", valid_cyc - v0, 0);
`else
        check("break_accepts", acc_cnt - a0, 1);
        check("break_data", acc_data, 8'h00);
        check("break_ferr", acc_ferr, 1);
`endif
        check("break_no_overrun", ovr_cnt - o0, 0);
        check("break_busy", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
